// File: rtl/seq_datapath.sv
// Multi-cycle register-file datapath: IDLE -> RDA -> RDB -> EXEC -> WB, one op per five cycles.
// Operands come from an NREG x W register file, pass through a shift/imm/zero mux and a 2-bit ALU.
module seq_datapath #(
  parameter int W    = 16,
  parameter int NREG = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [$clog2(NREG)-1:0]  rn,
  input  logic [$clog2(NREG)-1:0]  rm,
  input  logic [$clog2(NREG)-1:0]  rd,
  input  logic [1:0]               aluop,
  input  logic [1:0]               shift,
  input  logic                     zero_a,
  input  logic                     use_imm,
  input  logic [W-1:0]             imm,
  input  logic                     wb_sel,
  input  logic [W-1:0]             ext_in,
  input  logic                     write_en,
  input  logic                     set_flags,
  output logic                     busy,
  output logic                     done,
  output logic [W-1:0]             result,
  output logic                     flag_z,
  output logic                     flag_n,
  output logic                     flag_v
);
  localparam int RA = $clog2(NREG);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RDA  = 3'd1;
  localparam logic [2:0] RDB  = 3'd2;
  localparam logic [2:0] EXEC = 3'd3;
  localparam logic [2:0] WB   = 3'd4;

  typedef struct packed {
    logic [1:0]    aluop;
    logic [1:0]    shift;
    logic [RA-1:0] rn;
    logic [RA-1:0] rm;
    logic [RA-1:0] rd;
    logic          zero_a;
    logic          use_imm;
    logic [W-1:0]  imm;
    logic          wb_sel;
    logic [W-1:0]  ext;
    logic          write_en;
    logic          set_flags;
  } cmd_t;

  logic [2:0]   state;
  cmd_t         cmd;
  logic [W-1:0] rf [NREG];
  logic [W-1:0] a_q, b_q, c_q;
  logic         z_q, n_q, v_q;

  logic [W-1:0] b_sh, op_a, op_b, alu;
  logic         alu_v;

  always_comb begin
    b_sh = b_q;
    case (cmd.shift)
      2'b01:   b_sh = {b_q[W-2:0], 1'b0};
      2'b10:   b_sh = {1'b0, b_q[W-1:1]};
      2'b11:   b_sh = {b_q[W-1], b_q[W-1:1]};
      default: b_sh = b_q;
    endcase
    op_b  = cmd.use_imm ? cmd.imm : b_sh;
    op_a  = cmd.zero_a ? '0 : a_q;
    alu   = '0;
    alu_v = 1'b0;
    // Signed overflow: result sign disagrees with A when operand signs make that impossible
    case (cmd.aluop)
      2'b00: begin
        alu   = op_a + op_b;
        alu_v = (op_a[W-1] == op_b[W-1]) && (alu[W-1] != op_a[W-1]);
      end
      2'b01: begin
        alu   = op_a - op_b;
        alu_v = (op_a[W-1] != op_b[W-1]) && (alu[W-1] != op_a[W-1]);
      end
      2'b10:   alu = op_a & op_b;
      default: alu = ~op_b;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cmd   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      z_q   <= 1'b0;
      n_q   <= 1'b0;
      v_q   <= 1'b0;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= RDA;
          cmd   <= '{aluop: aluop, shift: shift, rn: rn, rm: rm, rd: rd,
                     zero_a: zero_a, use_imm: use_imm, imm: imm, wb_sel: wb_sel,
                     ext: ext_in, write_en: write_en, set_flags: set_flags};
        end
        RDA: begin
          a_q   <= rf[cmd.rn];
          state <= RDB;
        end
        RDB: begin
          b_q   <= rf[cmd.rm];
          state <= EXEC;
        end
        EXEC: begin
          c_q <= alu;
          if (cmd.set_flags) begin
            z_q <= (alu == '0);
            n_q <= alu[W-1];
            v_q <= alu_v;
          end
          state <= WB;
        end
        WB: begin
          if (cmd.write_en) rf[cmd.rd] <= cmd.wb_sel ? cmd.ext : c_q;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy   = (state != IDLE);
  assign done   = (state == WB);
  assign result = c_q;
  assign flag_z = z_q;
  assign flag_n = n_q;
  assign flag_v = v_q;
endmodule

// File: tb/tb_seq_datapath.sv
// Directed bench for seq_datapath: reference model computes expectations at issue,
// a scoreboard queue holds them until done.
module tb_seq_datapath;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  rn, rm, rd;
  logic [1:0]  aluop, shift;
  logic        zero_a, use_imm, wb_sel, write_en, set_flags;
  logic [15:0] imm, ext_in;
  logic        busy, done, flag_z, flag_n, flag_v;
  logic [15:0] result;

  typedef struct packed {
    logic [15:0] res;
    logic        z, n, v;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] mreg [8];
  logic        mz, mn, mv;
  int          tests = 0;
  int          fails = 0;

  seq_datapath #(.W(16), .NREG(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rn(rn), .rm(rm), .rd(rd),
    .aluop(aluop), .shift(shift), .zero_a(zero_a), .use_imm(use_imm), .imm(imm),
    .wb_sel(wb_sel), .ext_in(ext_in), .write_en(write_en), .set_flags(set_flags),
    .busy(busy), .done(done), .result(result),
    .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic scramble();
    rn = 3'($urandom); rm = 3'($urandom); rd = 3'($urandom);
    aluop = 2'($urandom); shift = 2'($urandom); zero_a = 1'($urandom);
    use_imm = 1'($urandom); imm = 16'($urandom); wb_sel = 1'($urandom);
    ext_in = 16'($urandom); write_en = 1'($urandom); set_flags = 1'($urandom);
  endtask

  // Must be called just after a falling edge while the DUT is idle; returns on a falling edge.
  task automatic op(input string tag, input logic [1:0] op_alu, input logic [1:0] op_sh,
                    input logic [2:0] a_idx, input logic [2:0] b_idx, input logic [2:0] d_idx,
                    input logic za, input logic ui, input logic [15:0] iv,
                    input logic ws, input logic [15:0] ev, input logic we, input logic sf);
    logic [15:0] a, b;
    int          sa, sbv, s;
    exp_t        e, got;
    int          n;
    start = 1'b1; aluop = op_alu; shift = op_sh; rn = a_idx; rm = b_idx; rd = d_idx;
    zero_a = za; use_imm = ui; imm = iv; wb_sel = ws; ext_in = ev;
    write_en = we; set_flags = sf;
    a = za ? 16'h0 : mreg[a_idx];
    b = mreg[b_idx];
    case (op_sh)
      2'd1:    b = b << 1;
      2'd2:    b = b >> 1;
      2'd3:    b = {b[15], b[15:1]};
      default: ;
    endcase
    if (ui) b = iv;
    sa = $signed(a); sbv = $signed(b);
    e.v = 1'b0;
    case (op_alu)
      2'd0: begin s = sa + sbv; e.res = s[15:0]; e.v = (s > 32767) || (s < -32768); end
      2'd1: begin s = sa - sbv; e.res = s[15:0]; e.v = (s > 32767) || (s < -32768); end
      2'd2: e.res = a & b;
      default: e.res = ~b;
    endcase
    if (sf) begin mz = (e.res == 16'h0); mn = e.res[15]; mv = e.v; end
    e.z = mz; e.n = mn; e.v = mv;
    sb.push_back(e);
    if (we) mreg[d_idx] = ws ? ev : e.res;

    @(posedge clk); #1;
    start = 1'b0;
    scramble();
    chk({tag, ".accept"}, 32'(busy), 32'd1);
    n = 0;
    while (!done && n < 8) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, ".latency"}, n, 32'd3);
    got = {result, flag_z, flag_n, flag_v};
    e = sb.pop_front();
    chk({tag, ".result"}, 32'(got.res), 32'(e.res));
    chk({tag, ".flags"}, {29'd0, got.z, got.n, got.v}, {29'd0, e.z, e.n, e.v});
    @(posedge clk); #1;
    chk({tag, ".idle"}, {30'd0, busy, done}, 32'd0);
    chk({tag, ".reg"}, 32'(dut.rf[d_idx]), 32'(mreg[d_idx]));
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0;
    rn = '0; rm = '0; rd = '0; aluop = '0; shift = '0; zero_a = 0; use_imm = 0;
    imm = '0; wb_sel = 0; ext_in = '0; write_en = 0; set_flags = 0;
    for (int i = 0; i < 8; i++) mreg[i] = 16'h0;
    mz = 0; mn = 0; mv = 0;

    #2 rst_n = 1'b0;
    #1;
    chk("reset.outs", {13'd0, busy, done, flag_z, flag_n, flag_v, result}, 32'd0);

    // Release and issue on the same falling edge: first rising edge must accept.
    @(negedge clk);
    rst_n = 1'b1;
    op("wr_r1", 2'd0, 2'd0, 3'd0, 3'd0, 3'd1, 0, 0, 16'h0, 1, 16'h0005, 1, 0);
    op("wr_r2", 2'd0, 2'd0, 3'd0, 3'd0, 3'd2, 0, 0, 16'h0, 1, 16'h0003, 1, 0);
    op("add",   2'd0, 2'd0, 3'd1, 3'd2, 3'd3, 0, 0, 16'h0, 0, 16'h0,    1, 1);

    op("wr_r1b", 2'd0, 2'd0, 3'd0, 3'd0, 3'd1, 0, 0, 16'h0, 1, 16'h7FFF, 1, 0);
    op("ovf",    2'd0, 2'd0, 3'd1, 3'd0, 3'd4, 0, 1, 16'h0001, 0, 16'h0, 1, 1);

    op("wr_r2b", 2'd0, 2'd0, 3'd0, 3'd0, 3'd2, 0, 0, 16'h0, 1, 16'h8004, 1, 0);
    op("asr",    2'd0, 2'd3, 3'd1, 3'd2, 3'd5, 1, 0, 16'h0, 0, 16'h0, 0, 1);
    op("lsr",    2'd0, 2'd2, 3'd1, 3'd2, 3'd5, 1, 0, 16'h0, 0, 16'h0, 0, 1);
    op("lsl",    2'd0, 2'd1, 3'd1, 3'd2, 3'd5, 1, 0, 16'h0, 0, 16'h0, 0, 1);

    op("wr_r1c", 2'd0, 2'd0, 3'd0, 3'd0, 3'd1, 0, 0, 16'h0, 1, 16'h1234, 1, 0);
    op("wr_r2c", 2'd0, 2'd0, 3'd0, 3'd0, 3'd2, 0, 0, 16'h0, 1, 16'h1234, 1, 0);
    op("sub0",   2'd1, 2'd0, 3'd1, 3'd2, 3'd6, 0, 0, 16'h0, 0, 16'h0, 1, 1);
    op("and_nf", 2'd2, 2'd0, 3'd1, 3'd3, 3'd6, 0, 0, 16'h0, 0, 16'h0, 0, 0);
    op("notb",   2'd3, 2'd0, 3'd0, 3'd2, 3'd7, 0, 0, 16'h0, 0, 16'h0, 1, 1);
    op("rd_eq",  2'd0, 2'd0, 3'd3, 3'd3, 3'd3, 0, 0, 16'h0, 0, 16'h0, 1, 1);
    op("no_wr",  2'd0, 2'd0, 3'd1, 3'd2, 3'd4, 0, 0, 16'h0, 0, 16'h0, 0, 0);

    // Result/flags hold while idle.
    repeat (3) @(posedge clk);
    #1;
    chk("hold", {13'd0, flag_z, flag_n, flag_v, result}, {13'd0, mz, mn, mv, 16'h2468});
    @(negedge clk);

    // Continuous start: no writes or flag updates, check the 5-cycle cadence.
    start = 1; write_en = 0; set_flags = 0; wb_sel = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      chk($sformatf("cont.busy%0d", k), 32'(busy), 32'((k % 5) != 4));
      chk($sformatf("cont.done%0d", k), 32'(done), 32'((k % 5) == 3));
    end
    start = 0;
    @(negedge clk);

    // Reset during EXEC aborts the write to r5.
    start = 1; aluop = 2'd0; shift = 2'd0; rn = 3'd1; rm = 3'd2; rd = 3'd5;
    zero_a = 0; use_imm = 0; wb_sel = 0; write_en = 1; set_flags = 1;
    @(posedge clk); #1;
    start = 0;
    @(posedge clk);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("rst_exec.outs", {13'd0, busy, done, flag_z, flag_n, flag_v, result}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_exec.r5", 32'(dut.rf[5]), 32'd0);
    chk("rst_exec.r1", 32'(dut.rf[1]), 32'd0);
    for (int i = 0; i < 8; i++) mreg[i] = 16'h0;
    mz = 0; mn = 0; mv = 0;
    @(negedge clk);

    op("post_wr", 2'd0, 2'd0, 3'd0, 3'd0, 3'd6, 0, 0, 16'h0, 1, 16'hA5A5, 1, 0);
    op("post_add", 2'd0, 2'd0, 3'd6, 3'd6, 3'd0, 0, 0, 16'h0, 0, 16'h0, 1, 1);

    chk("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
